// File: rtl/toggle_cover_tracker_if.sv
// Sample/coverage bundle between the monitored design side and the toggle-cover tracker.
interface toggle_cover_tracker_if #(
  parameter int WIDTH = 32
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             sample_en;
  logic             clear;
  logic [WIDTH-1:0] signal;
  logic [WIDTH-1:0] valid;
  logic [WIDTH-1:0] rise_seen;
  logic [WIDTH-1:0] fall_seen;
  logic [CNT_W-1:0] covered_count;
  logic             all_covered;

  modport master (
    output sample_en, clear, signal,
    input  valid, rise_seen, fall_seen, covered_count, all_covered
  );
  modport slave (
    input  sample_en, clear, signal,
    output valid, rise_seen, fall_seen, covered_count, all_covered
  );
endinterface

// File: rtl/toggle_cover_tracker.sv
// Per-bit sticky rise/fall toggle coverage with one-shot (or every-edge) valid pulses
// feeding the toggle-cover reporter, plus a registered covered-bit count.
module toggle_cover_lane #(
  parameter int ONESHOT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic sample_en,
  input  logic prev_ok,
  input  logic sig,
  output logic rise_seen,
  output logic fall_seen,
  output logic valid,
  output logic done_next
);
  logic prev;
  logic detect, rise, fall, valid_next;

  assign detect    = sample_en & prev_ok & ~clear;
  assign rise      = detect & ~prev & sig;
  assign fall      = detect & prev & ~sig;
  assign done_next = (rise_seen | rise) & (fall_seen | fall);

  generate
    if (ONESHOT != 0) begin : g_oneshot
      assign valid_next = done_next & ~(rise_seen & fall_seen);
    end else begin : g_every
      assign valid_next = rise | fall;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      prev      <= 1'b0;
      rise_seen <= 1'b0;
      fall_seen <= 1'b0;
      valid     <= 1'b0;
    end else begin
      if (sample_en) prev <= sig;
      if (clear) begin
        rise_seen <= 1'b0;
        fall_seen <= 1'b0;
        valid     <= 1'b0;
      end else begin
        rise_seen <= rise_seen | rise;
        fall_seen <= fall_seen | fall;
        valid     <= valid_next;
      end
    end
  end
endmodule

module toggle_cover_tracker #(
  parameter int WIDTH   = 32,
  parameter int ONESHOT = 1
) (
  input logic                  clock,
  input logic                  reset,
  toggle_cover_tracker_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             prev_ok;
  logic [WIDTH-1:0] done_next;
  logic [CNT_W-1:0] done_cnt;
  logic [CNT_W-1:0] covered_count;
  logic             all_covered;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      toggle_cover_lane #(.ONESHOT(ONESHOT)) u_lane (
        .clock     (clock),
        .reset     (reset),
        .clear     (bus.clear),
        .sample_en (bus.sample_en),
        .prev_ok   (prev_ok),
        .sig       (bus.signal[i]),
        .rise_seen (bus.rise_seen[i]),
        .fall_seen (bus.fall_seen[i]),
        .valid     (bus.valid[i]),
        .done_next (done_next[i])
      );
    end
  endgenerate

  always_comb begin
    done_cnt = '0;
    for (int b = 0; b < WIDTH; b++) done_cnt = done_cnt + CNT_W'(done_next[b]);
  end

  // A clear cycle that also samples reloads prev, so that sample is the new baseline.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_ok       <= 1'b0;
      covered_count <= '0;
      all_covered   <= 1'b0;
    end else if (bus.clear) begin
      prev_ok       <= bus.sample_en;
      covered_count <= '0;
      all_covered   <= 1'b0;
    end else begin
      if (bus.sample_en) prev_ok <= 1'b1;
      covered_count <= done_cnt;
      all_covered   <= (done_cnt == CNT_W'(WIDTH));
    end
  end

  assign bus.covered_count = covered_count;
  assign bus.all_covered   = all_covered;
endmodule
